// File: rtl/multicycle_ctrl_if.sv
// Purpose : fetch / register-file / ALU-select / data-memory signal bundle of multicycle_ctrl.
// Ports   : master = controller side (drives requests, addresses, strobes, pc, state_dbg);
//           slave = environment side (drives instr_valid, instr, mem_ack).
interface multicycle_ctrl_if #(
  parameter int PC_W = 8
);
  logic            instr_req;
  logic            instr_valid;
  logic [7:0]      instr;
  logic [PC_W-1:0] pc;
  logic [1:0]      rs_addr;
  logic [1:0]      rt_addr;
  logic [1:0]      wr_addr;
  logic [7:0]      sign_extended;
  logic            alusrc;
  logic            regwrite;
  logic            memread;
  logic            memwrite;
  logic            mem_ack;
  logic [2:0]      state_dbg;

  modport master (
    output instr_req, pc, rs_addr, rt_addr, wr_addr, sign_extended,
           alusrc, regwrite, memread, memwrite, state_dbg,
    input  instr_valid, instr, mem_ack
  );

  modport slave (
    input  instr_req, pc, rs_addr, rt_addr, wr_addr, sign_extended,
           alusrc, regwrite, memread, memwrite, state_dbg,
    output instr_valid, instr, mem_ack
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Purpose : multi-cycle fetch/decode/exec/mem/wb controller for the 8-bit datapath.
// Latency : add 4, j 3, lw 5+N, sw 4+N cycles (N = data-memory wait cycles).
// Backpr. : stalls in FETCH until instr_valid, holds memread/memwrite in MEM until mem_ack.
// Ports   : clk, reset_n (async, active-low); bus (multicycle_ctrl_if.master) carries the
//           fetch handshake, register-file addresses, immediate, ALU/memory strobes, pc, state_dbg.
//           MC_STEP_EN (optional macro) adds a `step` input: fetches happen only after a step pulse.
module multicycle_ctrl #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input logic clk,
  input logic reset_n,
`ifdef MC_STEP_EN
  input logic step,
`endif
  multicycle_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_e;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_J   = 2'b11;

  state_e          state_q;
  logic [7:0]      ir_q;
  logic [PC_W-1:0] pc_q;
  logic [1:0]      rs_q;
  logic [1:0]      rt_q;
  logic [1:0]      wa_q;
  logic [7:0]      se_q;

  logic [1:0]      op;
  logic [7:0]      imm_d;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_jmp;
  logic            fetch_go;
  logic            ir_load;

  assign op     = ir_q[7:6];
  assign pc_inc = pc_q + PC_W'(1);
  // Size cast of a signed operand sign-extends imm6 to the PC width; the sum wraps naturally.
  assign pc_jmp = pc_q + PC_W'(1) + PC_W'(signed'(ir_q[5:0]));

  always_comb begin
    imm_d = 8'h00;
    case (op)
      OP_LW, OP_SW: imm_d = {{6{ir_q[1]}}, ir_q[1:0]};
      OP_J:         imm_d = {{2{ir_q[5]}}, ir_q[5:0]};
      default:      imm_d = 8'h00;
    endcase
  end

`ifdef MC_STEP_EN
  logic step_pending_q;
  assign fetch_go = (state_q == FETCH) && step_pending_q;
`else
  assign fetch_go = (state_q == FETCH);
`endif

  assign ir_load = fetch_go && bus.instr_valid;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= FETCH;
      ir_q    <= 8'h00;
      pc_q    <= RESET_PC;
      rs_q    <= 2'd0;
      rt_q    <= 2'd0;
      wa_q    <= 2'd0;
      se_q    <= 8'h00;
    end else begin
      case (state_q)
        FETCH: begin
          if (ir_load) begin
            ir_q    <= bus.instr;
            state_q <= DECODE;
          end
        end
        DECODE: begin
          rs_q    <= ir_q[5:4];
          rt_q    <= ir_q[3:2];
          se_q    <= imm_d;
          state_q <= EXEC;
        end
        EXEC: begin
          case (op)
            OP_ADD: begin
              wa_q    <= ir_q[1:0];
              state_q <= WB;
            end
            OP_LW: begin
              wa_q    <= ir_q[3:2];
              state_q <= MEM;
            end
            OP_SW: state_q <= MEM;
            default: begin
              pc_q    <= pc_jmp;
              state_q <= FETCH;
            end
          endcase
        end
        MEM: begin
          if (bus.mem_ack) begin
            if (op == OP_LW) begin
              state_q <= WB;
            end else begin
              pc_q    <= pc_inc;
              state_q <= FETCH;
            end
          end
        end
        WB: begin
          pc_q    <= pc_inc;
          state_q <= FETCH;
        end
        default: state_q <= FETCH;  // encodings 5-7 recover in one cycle
      endcase
    end
  end

`ifdef MC_STEP_EN
  // A step arriving in any state is remembered; a new step wins over the clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      step_pending_q <= 1'b0;
    end else if (step) begin
      step_pending_q <= 1'b1;
    end else if (ir_load) begin
      step_pending_q <= 1'b0;
    end
  end
`endif

  // Strobes are gated by reset_n so they drop the instant reset asserts.
  assign bus.instr_req     = reset_n && fetch_go;
  assign bus.alusrc        = reset_n && (state_q == EXEC) && ((op == OP_LW) || (op == OP_SW));
  assign bus.memread       = reset_n && (state_q == MEM) && (op == OP_LW);
  assign bus.memwrite      = reset_n && (state_q == MEM) && (op == OP_SW);
  assign bus.regwrite      = reset_n && (state_q == WB);
  assign bus.pc            = pc_q;
  assign bus.rs_addr       = rs_q;
  assign bus.rt_addr       = rt_q;
  assign bus.wr_addr       = wa_q;
  assign bus.sign_extended = se_q;
  assign bus.state_dbg     = state_q;

endmodule
